// File: rtl/window_line_buffer.sv
// 3x3 sliding-window generator over a raster RGB565 stream, built from two line
// buffers and a column-shifting window register with a single-entry handshake.
module window_line_buffer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_pixel,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic             read,
  output logic             valid_buffer,
  output logic [8:0][15:0] pixel_buffer
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]      col_q, col_d, col_eff;
  logic [RW-1:0]      row_q, row_d, row_eff;
  logic               valid_q, valid_d;
  logic [8:0][15:0]   win_q, win_d;
  logic [15:0]        line1_mem [IMG_WIDTH];
  logic [15:0]        line2_mem [IMG_WIDTH];
  logic [15:0]        l1_rd, l2_rd;
  logic               accept, complete;

  assign in_ready     = !valid_q || read;
  assign accept       = in_valid && in_ready;
  assign valid_buffer = valid_q;
  assign pixel_buffer = win_q;

  always_comb begin
    // A start-of-frame pixel overrides the running position.
    col_eff  = in_sof ? '0 : col_q;
    row_eff  = in_sof ? '0 : row_q;
    l1_rd    = line1_mem[col_eff];
    l2_rd    = line2_mem[col_eff];
    complete = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));

    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = l2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = l1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pixel;
      if (col_eff == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IMG_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end

    if (complete) begin
      valid_d = 1'b1;
    end else if (read) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  // Line storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      line2_mem[col_eff] <= l1_rd;
      line1_mem[col_eff] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed-vector bench for window_line_buffer on a 4x4 image with pixels
// numbered in raster order.
module tb_window_line_buffer;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [15:0]      in_pixel;
  logic             in_sof;
  logic             in_ready;
  logic             read;
  logic             valid_buffer;
  logic [8:0][15:0] pixel_buffer;

  int nvec = 0;
  int nmis = 0;

  window_line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_pixel     (in_pixel),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .read         (read),
    .valid_buffer (valid_buffer),
    .pixel_buffer (pixel_buffer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [15:0]      pix;
    logic             sof;
    logic             rd;
    logic             exp_ready;
    logic             exp_vb;
    logic [8:0][15:0] exp_win;
  } vec_t;

  vec_t tbl[17];
  logic [8:0][15:0] w10, w11, w14, w15, wb10;

  function automatic logic [8:0][15:0] win(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    logic [8:0][15:0] w;
    w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
    w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
    w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
    return w;
  endfunction

  function automatic vec_t mk(input logic v, input int pix, input logic sof, input logic rd,
                              input logic er, input logic evb, input logic [8:0][15:0] ew);
    vec_t t;
    t.v = v; t.pix = 16'(pix); t.sof = sof; t.rd = rd;
    t.exp_ready = er; t.exp_vb = evb; t.exp_win = ew;
    return t;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    in_valid = t.v; in_pixel = t.pix; in_sof = t.sof; read = t.rd;
    #1;
    chk({tag, "_ready"}, 144'(in_ready), 144'(t.exp_ready));
    @(posedge clk);
    #1;
    chk({tag, "_vb"}, 144'(valid_buffer), 144'(t.exp_vb));
    if (t.exp_vb) chk({tag, "_win"}, pixel_buffer, t.exp_win);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("%s%0d", tag, i));
  endtask

  task automatic idle(input string tag);
    step(mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0), tag);
  endtask

  function automatic logic [8:0][15:0] exp_window(input int p);
    case (p)
      10:      return w10;
      11:      return w11;
      14:      return w14;
      default: return w15;
    endcase
  endfunction

  initial begin
    int          k;
    logic        mvb;
    logic [8:0][15:0] mwin;
    logic        v, rd, er, acc;

    w10  = win(0, 1, 2, 4, 5, 6, 8, 9, 10);
    w11  = win(1, 2, 3, 5, 6, 7, 9, 10, 11);
    w14  = win(4, 5, 6, 8, 9, 10, 12, 13, 14);
    w15  = win(5, 6, 7, 9, 10, 11, 13, 14, 15);
    wb10 = win(100, 101, 102, 104, 105, 106, 108, 109, 110);

    for (int i = 0; i < 16; i++) tbl[i] = mk(1'b1, i, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    tbl[10].exp_vb = 1'b1; tbl[10].exp_win = w10;
    tbl[11].exp_vb = 1'b1; tbl[11].exp_win = w11;
    tbl[14].exp_vb = 1'b1; tbl[14].exp_win = w14;
    tbl[15].exp_vb = 1'b1; tbl[15].exp_win = w15;
    tbl[16] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Reset state
    in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; read = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_vb", 144'(valid_buffer), 144'(0));
    chk("rst_win", pixel_buffer, 144'(0));
    chk("rst_ready", 144'(in_ready), 144'(1));
    @(negedge clk);
    reset = 1'b0;

    // Plain frame, no in_sof after reset
    run_table("frame");

    // Back-pressure: hold the first window for five cycles
    for (int i = 0; i <= 10; i++) step(tbl[i], $sformatf("bp%0d", i));
    for (int i = 0; i < 5; i++)
      step(mk(1'b1, 11, 1'b0, 1'b0, 1'b0, 1'b1, w10), $sformatf("hold%0d", i));
    for (int i = 11; i < 17; i++) step(tbl[i], $sformatf("bp%0d", i));

    // Mid-frame reset
    for (int i = 0; i <= 6; i++) step(tbl[i], $sformatf("pre%0d", i));
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    #1;
    chk("mrst_async_win", pixel_buffer, 144'(0));
    chk("mrst_async_vb", 144'(valid_buffer), 144'(0));
    chk("mrst_ready", 144'(in_ready), 144'(1));
    @(posedge clk);
    #1;
    chk("mrst_win", pixel_buffer, 144'(0));
    @(negedge clk);
    reset = 1'b0;
    run_table("restream");

    // Frame A, stray partial frame, then frame B restarted by in_sof
    run_table("frameA");
    for (int i = 0; i < 5; i++)
      step(mk(1'b1, 200 + i, 1'b0, 1'b1, 1'b1, 1'b0, '0), $sformatf("stray%0d", i));
    for (int i = 0; i <= 10; i++)
      step(mk(1'b1, 100 + i, i == 0, 1'b1, 1'b1, i == 10, wb10), $sformatf("frameB%0d", i));
    idle("clr");

    // Random in_valid and read; windows checked against the expected sequence
    k = 0; mvb = 1'b0; mwin = '0;
    for (int cyc = 0; cyc < 300 && k < 16; cyc++) begin
      @(negedge clk);
      v  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      in_valid = v; in_pixel = 16'(k); in_sof = (k == 0); read = rd;
      #1;
      er  = !mvb || rd;
      acc = v && er;
      chk($sformatf("rnd_ready_c%0d", cyc), 144'(in_ready), 144'(er));
      @(posedge clk);
      #1;
      if (acc && (k == 10 || k == 11 || k == 14 || k == 15)) begin
        mvb  = 1'b1;
        mwin = exp_window(k);
      end else if (rd) begin
        mvb = 1'b0;
      end
      if (acc) k++;
      chk($sformatf("rnd_vb_c%0d", cyc), 144'(valid_buffer), 144'(mvb));
      if (mvb) chk($sformatf("rnd_win_c%0d", cyc), pixel_buffer, mwin);
    end
    chk("rnd_all_accepted", 144'(k), 144'(16));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
